serial_adder: RTL and testbench
===============================

# serial_adder

LSB-first bit-serial adder that is the additive counterpart of the team's half-subtractor arithmetic cells. It parallel-loads two WIDTH-bit operands on a start strobe and resolves one sum bit per clock through a single full-adder cell with a registered carry. It presents the registered sum and carry-out with a one-cycle done pulse. The block sits in the arithmetic datapath where area matters more than latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range is 2 to 32.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  WIDTH  augend; captured on the accepted start edge.
- b  input  WIDTH  addend; captured on the accepted start edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; sum and carry are valid.
- sum  output  WIDTH  registered result; held until the next completion.
- carry  output  1  registered carry-out of the MSB; held with sum.

## Operation
- FSM states:
  - IDLE: busy=0, done=0. If start=1, load a and b into shift registers, clear the internal carry to 0, clear the bit counter to 0, and go to SHIFT.
  - SHIFT: each edge processes the LSBs of the a/b shift registers through the cell.
    - s = a0^b0^c, c_next = majority(a0, b0, c).
    - Shift s into the MSB of the partial-sum register; shift the a/b registers right by one.
    - Increment the counter.
    - On the edge that processes bit WIDTH-1, copy the partial sum to sum and c_next to carry, then go to DONE.
  - DONE: done=1, busy=1. Next edge goes to IDLE unconditionally.
- start is ignored in SHIFT and DONE. The operands in flight are not disturbed.
- a and b are sampled only on the accepted start edge. Later changes have no effect.
- sum and carry change only on the completing edge. During a computation they keep the previous result.
- Arithmetic: {carry, sum} equals a + b, unsigned, WIDTH+1 bits exact. No saturation.
- Reset (asynchronous, any state, including mid-SHIFT):
  - State goes to IDLE.
  - sum, carry, the internal carry, the counter, the shift registers, busy and done all go to 0.
  - A partial result is discarded; no done pulse follows.
- Reset values of the outputs: busy=0, done=0, sum=0, carry=0.

## Timing
- The accepted start edge is edge k (state IDLE, start=1). busy=1 from just after edge k.
- Edges k+1 through k+WIDTH process bits 0 through WIDTH-1.
- After edge k+WIDTH, done=1 and the new sum/carry are visible for exactly one cycle.
- After edge k+WIDTH+1, state is IDLE and busy=0. start sampled at this edge is ignored; the earliest next accepted start is edge k+WIDTH+2.
- Latency: WIDTH cycles from the accepted start edge to done. Throughput: one operation per WIDTH+2 cycles.
- If start is held high continuously, back-to-back operations are accepted at each IDLE edge, every WIDTH+2 cycles, with new operand samples each time.
- Reset deasserted on a given edge: the first start can be accepted on the following rising edge.

## Structure
- Package serial_adder_pkg holds:
  - the state enum {IDLE, SHIFT, DONE}, 2 bits;
  - a function returning the counter width, $clog2(WIDTH);
  - the WIDTH legal-range constants (2, 32).
- Sub-module full_adder_cell is combinational: inputs x, y, cin; outputs s, cout. It is instantiated once.
- The FSM, counter, shift registers and result registers live in serial_adder.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Reset with rst_n=0 for 3 cycles, then release -> busy=0, done=0, sum=0x00, carry=0; no done pulse in the next 20 cycles with start=0.
- a=0xFF, b=0x01, start pulsed at edge k -> done high exactly in the cycle after edge k+8; sum=0x00, carry=1; busy low after edge k+9.
- a=0xA5, b=0x5A -> sum=0xFF, carry=0. Then a=0x80, b=0x80 -> sum=0x00, carry=1. During the second operation, sum reads 0xFF until its done.
- Start a=0x01, b=0x02; during SHIFT change a/b to 0x7F/0x7F and pulse start again -> second start ignored; sum=0x03, carry=0; exactly one done pulse.
- Start a=0x3C, b=0x0F; assert rst_n=0 asynchronously mid-cycle after edge k+4 -> outputs go to 0 immediately, no done pulse. After release, a=0x10, b=0x20 -> sum=0x30, carry=0.
- WIDTH=4: exhaustive 256 operand pairs, start held high -> every done gives {carry, sum}=a+b; done pulses spaced 6 cycles apart.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the LSB-first bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder; the only arithmetic logic in the serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per clock through a single full-adder cell.
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepted edge
//   SHIFT | one operand bit pair resolved per edge, LSB first
//   DONE  | one-cycle done pulse; sum/carry hold the new result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = cnt_width(WIDTH);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, psum;
  logic             c_int;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_cout;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_adder_cell u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .cin (c_int),
    .s   (cell_s),
    .cout(cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // sum/carry only move on the completing edge so readers see the last result throughout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      c_int <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c_int <= 1'b0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= {cell_s, psum[WIDTH-1:1]};
          c_int <= cell_cout;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum   <= {cell_s, psum[WIDTH-1:1]};
            carry <= cell_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, carry;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-edge start pulse; returns 1 ns after the accepted edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (sum !== 8'h00) begin tests_failed++; $display("FAIL reset_sum: got %h expected 00", sum); end
    tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("FAIL reset_carry: got %b expected 0", carry); end
    pulses = 0;
    repeat (20) begin
      step();
      if (done) pulses++;
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL reset_idle_done: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_overflow();
    logic early;
    launch(8'hFF, 8'h01);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ovf_busy_start: got %b expected 1", busy); end
    early = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (done) early = 1'b1;
    end
    tests_run++; if (early !== 1'b0) begin tests_failed++; $display("FAIL ovf_early_done: got %b expected 0", early); end
    step();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL ovf_done_edge8: got %b expected 1", done); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ovf_busy_in_done: got %b expected 1", busy); end
    tests_run++; if (sum !== 8'h00) begin tests_failed++; $display("FAIL ovf_sum: got %h expected 00", sum); end
    tests_run++; if (carry !== 1'b1) begin tests_failed++; $display("FAIL ovf_carry: got %b expected 1", carry); end
    step();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL ovf_done_width: got %b expected 0", done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ovf_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic got, held;
    launch(8'hA5, 8'h5A);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (done) got = 1'b1;
    end
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_done: got %b expected 1", got); end
    tests_run++; if (sum !== 8'hFF) begin tests_failed++; $display("FAIL b2b_first_sum: got %h expected ff", sum); end
    tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("FAIL b2b_first_carry: got %b expected 0", carry); end
    step();
    launch(8'h80, 8'h80);
    got = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (sum !== 8'hFF) held = 1'b0;
      step();
      if (done) got = 1'b1;
    end
    tests_run++; if (held !== 1'b1) begin tests_failed++; $display("FAIL b2b_sum_held: got %b expected 1", held); end
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_done: got %b expected 1", got); end
    tests_run++; if (sum !== 8'h00) begin tests_failed++; $display("FAIL b2b_second_sum: got %h expected 00", sum); end
    tests_run++; if (carry !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_carry: got %b expected 1", carry); end
    step();
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [7:0] rs;
    logic rc;
    pulses = 0;
    rs = 8'hXX;
    rc = 1'bx;
    launch(8'h01, 8'h02);
    step();
    a = 8'h7F;
    b = 8'h7F;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) begin
      step();
      if (done) begin
        pulses++;
        rs = sum;
        rc = carry;
      end
    end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL ign_pulses: got %0d expected 1", pulses); end
    tests_run++; if (rs !== 8'h03) begin tests_failed++; $display("FAIL ign_sum: got %h expected 03", rs); end
    tests_run++; if (rc !== 1'b0) begin tests_failed++; $display("FAIL ign_carry: got %b expected 0", rc); end
  endtask

  task automatic test_async_reset();
    int pulses;
    logic got;
    launch(8'h3C, 8'h0F);
    repeat (4) step();
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL arst_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL arst_done: got %b expected 0", done); end
    tests_run++; if (sum !== 8'h00) begin tests_failed++; $display("FAIL arst_sum: got %h expected 00", sum); end
    tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("FAIL arst_carry: got %b expected 0", carry); end
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      step();
      if (done) pulses++;
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL arst_no_done: got %0d pulses expected 0", pulses); end
    launch(8'h10, 8'h20);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (done) got = 1'b1;
    end
    tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL arst_after_done: got %b expected 1", got); end
    tests_run++; if (sum !== 8'h30) begin tests_failed++; $display("FAIL arst_after_sum: got %h expected 30", sum); end
    tests_run++; if (carry !== 1'b0) begin tests_failed++; $display("FAIL arst_after_carry: got %b expected 0", carry); end
    step();
  endtask

  task automatic test_width4_exhaustive();
    int cyc, last_cyc;
    logic got;
    logic [4:0] exp;
    logic [3:0] ea, eb;
    cyc = 0;
    last_cyc = 0;
    a4 = 4'd0;
    b4 = 4'd0;
    start4 = 1'b1;
    for (int n = 0; n < 256; n++) begin
      ea = 4'(n >> 4);
      eb = 4'(n);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
        step();
        cyc++;
        if (done4) got = 1'b1;
      end
      tests_run++;
      if (got !== 1'b1) begin
        tests_failed++;
        $display("FAIL w4_timeout: pair %0d got no done expected done", n);
        break;
      end
      exp = {1'b0, ea} + {1'b0, eb};
      tests_run++;
      if ({carry4, sum4} !== exp) begin
        tests_failed++;
        $display("FAIL w4_sum: a=%h b=%h got %h expected %h", ea, eb, {carry4, sum4}, exp);
      end
      if (n > 0) begin
        tests_run++;
        if (cyc - last_cyc != 6) begin
          tests_failed++;
          $display("FAIL w4_spacing: pair %0d got %0d cycles expected 6", n, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      if (n < 255) begin
        a4 = 4'((n + 1) >> 4);
        b4 = 4'(n + 1);
      end else begin
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_width4_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
